// File: rtl/pool_window_gen.sv
// Producer side of the max-pooling window interface. Takes a row-major pixel
// stream, keeps the previous (even) row in a line buffer, and emits
// non-overlapping 2x2 windows with stride 2 through a single output stage.
module pool_window_gen #(
  parameter int unsigned DataWidth  = 20,
  parameter int unsigned FmapWidth  = 8,
  parameter int unsigned FmapHeight = 8,
  parameter int unsigned PoolSize   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [DataWidth-1:0]                pix_in_i,
  input  logic                                pix_valid_i,
  output logic                                pix_ready_o,
  output logic [PoolSize-1:0][DataWidth-1:0]  ifm_window_o,
  output logic                                win_valid_o,
  input  logic                                win_ready_i,
  output logic                                win_last_o,
  output logic                                frame_done_o
);

  localparam int unsigned ColW = (FmapWidth > 2) ? $clog2(FmapWidth) : 1;
  localparam int unsigned RowW = (FmapHeight > 2) ? $clog2(FmapHeight) : 1;

  // Only a 2x2 window over even-sized maps is supported.
  if (PoolSize != 4) begin : gen_bad_pool_size
    $error("pool_window_gen: PoolSize must be 4 (2x2 window)");
  end
  if ((FmapWidth < 2) || (FmapWidth % 2 != 0)) begin : gen_bad_width
    $error("pool_window_gen: FmapWidth must be even and >= 2");
  end
  if ((FmapHeight < 2) || (FmapHeight % 2 != 0)) begin : gen_bad_height
    $error("pool_window_gen: FmapHeight must be even and >= 2");
  end

  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [DataWidth-1:0] linebuf_q [FmapWidth];
  logic [DataWidth-1:0] left_q;
  logic [PoolSize-1:0][DataWidth-1:0] win_q, win_d;
  logic                 win_valid_q, win_valid_d;
  logic                 win_last_q, win_last_d;
  logic                 frame_done_q, frame_done_d;

  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            odd_row;
  logic            complete;
  logic [ColW-1:0] col_even;

  // Handshake and position decode for the pixel currently presented.
  always_comb begin
    pix_ready_o = !win_valid_q || win_ready_i;
    accept      = pix_valid_i && pix_ready_o;
    col_last    = (col_q == ColW'(FmapWidth - 1));
    row_last    = (row_q == RowW'(FmapHeight - 1));
    odd_row     = row_q[0];
    complete    = accept && odd_row && col_q[0];
    // Left column of the current window pair (col_q is odd when completing).
    col_even    = col_q & ~ColW'(1);
  end

  // Next-state for the column/row counters, window stage and frame pulse.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = accept && row_last && col_last;

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    // A new window wins over a consume in the same cycle, so valid stays high.
    if (complete) begin
      win_d[0]    = linebuf_q[col_even];
      win_d[1]    = linebuf_q[col_q];
      win_d[2]    = left_q;
      win_d[3]    = pix_in_i;
      win_valid_d = 1'b1;
      win_last_d  = row_last && col_last;
    end else if (win_valid_q && win_ready_i) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      if (accept && odd_row && !col_q[0]) begin
        left_q <= pix_in_i;
      end
    end
  end

  // Line buffer captures every even row; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (accept && !odd_row) begin
      linebuf_q[col_q] <= pix_in_i;
    end
  end

  // Registered outputs.
  always_comb begin
    ifm_window_o = win_q;
    win_valid_o  = win_valid_q;
    win_last_o   = win_last_q;
    frame_done_o = frame_done_q;
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x4 instance for streaming, backpressure,
// reset and back-to-back frames, plus an 8x2 instance for the wide-row case.
module tb_pool_window_gen;

  logic clk;
  logic rst_n;

  logic [19:0]       pix4, pix8;
  logic              v4, v8, wr4, wr8;
  logic              pr4, pr8;
  logic [3:0][19:0]  win4, win8;
  logic              wv4, wv8, wl4, wl8, fd4, fd8;

  int vectors = 0;
  int errs    = 0;

  pool_window_gen #(
    .DataWidth (20),
    .FmapWidth (4),
    .FmapHeight(4),
    .PoolSize  (4)
  ) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pix_in_i    (pix4),
    .pix_valid_i (v4),
    .pix_ready_o (pr4),
    .ifm_window_o(win4),
    .win_valid_o (wv4),
    .win_ready_i (wr4),
    .win_last_o  (wl4),
    .frame_done_o(fd4)
  );

  pool_window_gen #(
    .DataWidth (20),
    .FmapWidth (8),
    .FmapHeight(2),
    .PoolSize  (4)
  ) dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pix_in_i    (pix8),
    .pix_valid_i (v8),
    .pix_ready_o (pr8),
    .ifm_window_o(win8),
    .win_valid_o (wv8),
    .win_ready_i (wr8),
    .win_last_o  (wl8),
    .frame_done_o(fd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][19:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][19:0] r;
    r[0] = a[19:0];
    r[1] = b[19:0];
    r[2] = c[19:0];
    r[3] = d[19:0];
    return r;
  endfunction

  // Hand-derived 4x4 windows keyed by the completing pixel index.
  function automatic logic [3:0][19:0] exp4(input int base, input int p);
    case (p)
      5:       return mk(base + 0, base + 1, base + 4, base + 5);
      7:       return mk(base + 2, base + 3, base + 6, base + 7);
      13:      return mk(base + 8, base + 9, base + 12, base + 13);
      default: return mk(base + 10, base + 11, base + 14, base + 15);
    endcase
  endfunction

  // Streams pixels base+first..base+last into dut4 back-to-back, win_ready high.
  task automatic run4(input int base, input int first, input int last);
    logic ev;
    for (int p = first; p <= last; p++) begin
      chk($sformatf("pix_ready4 p%0d", p), 80'(pr4), 80'(1'b1));
      v4   = 1'b1;
      pix4 = 20'(base + p);
      @(posedge clk);
      #1;
      v4 = 1'b0;
      ev = (p == 5) || (p == 7) || (p == 13) || (p == 15);
      chk($sformatf("win_valid4 b%0d p%0d", base, p), 80'(wv4), 80'(ev));
      if (ev) chk($sformatf("window4 b%0d p%0d", base, p), 80'(win4), 80'(exp4(base, p)));
      chk($sformatf("win_last4 b%0d p%0d", base, p), 80'(wl4), 80'(p == 15));
      chk($sformatf("frame_done4 b%0d p%0d", base, p), 80'(fd4), 80'(p == 15));
    end
  endtask

  task automatic idle4(input string tag);
    v4 = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " idle win_valid"}, 80'(wv4), 80'(1'b0));
    chk({tag, " idle frame_done"}, 80'(fd4), 80'(1'b0));
  endtask

  initial begin
    logic ev;
    logic [3:0][19:0] w8;
    rst_n = 1'b0;
    v4 = 1'b0; v8 = 1'b0; wr4 = 1'b1; wr8 = 1'b1;
    pix4 = '0; pix8 = '0;

    // Reset state
    #12;
    chk("rst win_valid", 80'(wv4), 80'(1'b0));
    chk("rst win_last", 80'(wl4), 80'(1'b0));
    chk("rst frame_done", 80'(fd4), 80'(1'b0));
    chk("rst window", 80'(win4), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst pix_ready", 80'(pr4), 80'(1'b1));

    // Plain 4x4 frame at full throughput
    run4(0, 0, 15);
    idle4("frame1");

    // Backpressure: hold win_ready low for 5 cycles after first window
    run4(0, 0, 5);
    wr4  = 1'b0;
    v4   = 1'b1;
    pix4 = 20'd6;
    #1;
    chk("bp pix_ready start", 80'(pr4), 80'(1'b0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp pix_ready c%0d", i), 80'(pr4), 80'(1'b0));
      chk($sformatf("bp win_valid c%0d", i), 80'(wv4), 80'(1'b1));
      chk($sformatf("bp window c%0d", i), 80'(win4), 80'(mk(0, 1, 4, 5)));
    end
    wr4 = 1'b1;
    #1;
    chk("bp pix_ready release", 80'(pr4), 80'(1'b1));
    @(posedge clk);
    #1;
    v4 = 1'b0;
    chk("bp consumed", 80'(wv4), 80'(1'b0));
    run4(0, 7, 15);
    idle4("bp");

    // Reset mid-frame after pixel 6, then a clean replay
    run4(0, 0, 6);
    rst_n = 1'b0;
    #1;
    chk("midrst win_valid", 80'(wv4), 80'(1'b0));
    chk("midrst win_last", 80'(wl4), 80'(1'b0));
    chk("midrst frame_done", 80'(fd4), 80'(1'b0));
    chk("midrst window", 80'(win4), 80'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst pix_ready", 80'(pr4), 80'(1'b1));
    run4(0, 0, 15);
    idle4("replay");

    // Back-to-back frames with no gap
    run4(0, 0, 15);
    run4(100, 0, 15);
    idle4("b2b");

    // 8x2 map: windows pair row 0 with row 1
    for (int p = 0; p < 16; p++) begin
      v8   = 1'b1;
      pix8 = 20'(p);
      @(posedge clk);
      #1;
      v8 = 1'b0;
      ev = (p == 9) || (p == 11) || (p == 13) || (p == 15);
      chk($sformatf("win_valid8 p%0d", p), 80'(wv8), 80'(ev));
      if (ev) begin
        case (p)
          9:       w8 = mk(0, 1, 8, 9);
          11:      w8 = mk(2, 3, 10, 11);
          13:      w8 = mk(4, 5, 12, 13);
          default: w8 = mk(6, 7, 14, 15);
        endcase
        chk($sformatf("window8 p%0d", p), 80'(win8), 80'(w8));
      end
      chk($sformatf("win_last8 p%0d", p), 80'(wl8), 80'(p == 15));
      chk($sformatf("frame_done8 p%0d", p), 80'(fd8), 80'(p == 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
